// File: rtl/lsu_mem_master_if.sv
// Word-addressed data-memory port between the LSU initiator and the memory responder.
// The initiator drives request/address/enables/data; the responder returns ack and read data.
interface lsu_mem_master_if;
  logic        MemReq;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [3:0]  MemByteEn;
  logic [31:0] MemWData;
  logic        MemAck;
  logic [31:0] MemRData;

  modport master (
    output MemReq, MemWe, MemAddr, MemByteEn, MemWData,
    input  MemAck, MemRData
  );

  modport slave (
    input  MemReq, MemWe, MemAddr, MemByteEn, MemWData,
    output MemAck, MemRData
  );
endinterface

// File: rtl/lsu_mem_master.sv
// LSU memory initiator: turns one MEM-stage load/store into a byte-enabled word request,
// stalls the pipeline until ack or timeout, and returns extended load data.
module lsu_mem_master #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        LsValid,
  input  logic        LsIsStore,
  input  logic [1:0]  LsSize,
  input  logic        LsSignExt,
  input  logic [31:0] LsAddr,
  input  logic [31:0] LsWData,
  output logic        LsStall,
  output logic        LsDone,
  output logic [31:0] LsRData,
  output logic        LsAdEL,
  output logic        LsAdES,
  output logic        LsBusErr,
  lsu_mem_master_if.master mem
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    q_size;
  logic          q_sext;
  logic [1:0]    q_lo;

  logic          legal;
  logic [3:0]    be_n;
  logic [31:0]   wd_n;
  logic [31:0]   rd_fmt;
  logic [15:0]   half;
  logic [7:0]    byte_l;

  always_comb begin
    legal = 1'b0;
    be_n  = 4'b0000;
    wd_n  = 32'h0;
    unique case (LsSize)
      2'b00: begin
        legal = (LsAddr[1:0] == 2'b00);
        be_n  = 4'b1111;
        wd_n  = LsWData;
      end
      2'b01: begin
        legal = ~LsAddr[0];
        be_n  = LsAddr[1] ? 4'b1100 : 4'b0011;
        wd_n  = {2{LsWData[15:0]}};
      end
      2'b10: begin
        legal = 1'b1;
        be_n  = 4'b0001 << LsAddr[1:0];
        wd_n  = {4{LsWData[7:0]}};
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

  // Lane select uses the address latched at accept, not the live pipeline input.
  always_comb begin
    half   = q_lo[1] ? mem.MemRData[31:16] : mem.MemRData[15:0];
    byte_l = 8'h0;
    unique case (q_lo)
      2'b00: byte_l = mem.MemRData[7:0];
      2'b01: byte_l = mem.MemRData[15:8];
      2'b10: byte_l = mem.MemRData[23:16];
      default: byte_l = mem.MemRData[31:24];
    endcase
    rd_fmt = mem.MemRData;
    unique case (q_size)
      2'b01:   rd_fmt = {{16{q_sext & half[15]}}, half};
      2'b10:   rd_fmt = {{24{q_sext & byte_l[7]}}, byte_l};
      default: rd_fmt = mem.MemRData;
    endcase
  end

  always_comb begin
    LsStall = (state == REQ) || (state == IDLE && LsValid && legal);
    LsAdEL  = (state == IDLE) && LsValid && !legal && !LsIsStore;
    LsAdES  = (state == IDLE) && LsValid && !legal && LsIsStore;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      q_size        <= 2'b00;
      q_sext        <= 1'b0;
      q_lo          <= 2'b00;
      mem.MemReq    <= 1'b0;
      mem.MemWe     <= 1'b0;
      mem.MemAddr   <= 32'h0;
      mem.MemByteEn <= 4'h0;
      mem.MemWData  <= 32'h0;
      LsRData       <= 32'h0;
      LsDone        <= 1'b0;
      LsBusErr      <= 1'b0;
    end else begin
      LsDone   <= 1'b0;
      LsBusErr <= 1'b0;
      unique case (state)
        IDLE: begin
          if (LsValid && legal) begin
            q_size        <= LsSize;
            q_sext        <= LsSignExt;
            q_lo          <= LsAddr[1:0];
            mem.MemReq    <= 1'b1;
            mem.MemWe     <= LsIsStore;
            mem.MemAddr   <= {LsAddr[31:2], 2'b00};
            mem.MemByteEn <= be_n;
            mem.MemWData  <= wd_n;
            cnt           <= '0;
            state         <= REQ;
          end
        end
        REQ: begin
          // Ack has priority over a coincident timeout.
          if (mem.MemAck) begin
            mem.MemReq <= 1'b0;
            if (!mem.MemWe) LsRData <= rd_fmt;
            LsDone     <= 1'b1;
            cnt        <= '0;
            state      <= DONE;
          end else if (cnt == CNT_MAX) begin
            mem.MemReq <= 1'b0;
            LsBusErr   <= 1'b1;
            cnt        <= '0;
            state      <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master: ops push expected requests/completions,
// the responder and completion monitor pop and compare them.
module tb_lsu_mem_master;
  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        LsValid = 1'b0;
  logic        LsIsStore = 1'b0;
  logic [1:0]  LsSize = 2'b00;
  logic        LsSignExt = 1'b0;
  logic [31:0] LsAddr = 32'h0;
  logic [31:0] LsWData = 32'h0;
  logic        LsStall, LsDone, LsAdEL, LsAdES, LsBusErr;
  logic [31:0] LsRData;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  lsu_mem_master_if bus ();

  lsu_mem_master #(.TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .LsValid   (LsValid),
    .LsIsStore (LsIsStore),
    .LsSize    (LsSize),
    .LsSignExt (LsSignExt),
    .LsAddr    (LsAddr),
    .LsWData   (LsWData),
    .LsStall   (LsStall),
    .LsDone    (LsDone),
    .LsRData   (LsRData),
    .LsAdEL    (LsAdEL),
    .LsAdES    (LsAdES),
    .LsBusErr  (LsBusErr),
    .mem       (bus.master)
  );

  initial forever begin
    #5 clk = 1'b1;
    cyc++;
    #5 clk = 1'b0;
  end

  initial begin
    #500us;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    int          cyc;
  } req_t;

  typedef struct {
    logic        berr;
    logic [31:0] rd;
    int          cyc;
  } done_t;

  req_t  rq[$];
  done_t dq[$];

  int          ack_delay = 0;
  bit          no_ack = 1'b0;
  logic [31:0] rd_word = 32'h0;
  logic [31:0] last_rd = 32'h0;
  int          wcnt = 0;
  req_t        re;
  done_t       de;

  function automatic logic [3:0] exp_be(logic [1:0] sz, logic [31:0] a);
    case (sz)
      2'b00:   return 4'b1111;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b0001 << a[1:0];
    endcase
  endfunction

  function automatic logic [31:0] exp_wd(logic [1:0] sz, logic [31:0] wd);
    case (sz)
      2'b00:   return wd;
      2'b01:   return {wd[15:0], wd[15:0]};
      default: return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
    endcase
  endfunction

  function automatic logic [31:0] fmt(logic [1:0] sz, bit sx, logic [31:0] a, logic [31:0] w);
    logic [31:0] s;
    case (sz)
      2'b01: begin
        s = w >> (a[1] ? 16 : 0);
        return sx ? {{16{s[15]}}, s[15:0]} : {16'h0, s[15:0]};
      end
      2'b10: begin
        s = w >> (8 * a[1:0]);
        return sx ? {{24{s[7]}}, s[7:0]} : {24'h0, s[7:0]};
      end
      default: return w;
    endcase
  endfunction

  // Responder: checks each new request against the queue, acks after ack_delay wait cycles.
  initial begin
    bus.MemAck   = 1'b0;
    bus.MemRData = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.MemReq === 1'b1) begin
        if (wcnt == 0) begin
          re = '{we: 1'bx, addr: 'x, be: 'x, wd: 'x, cyc: -1};
          if (rq.size() > 0) re = rq.pop_front();
          check("req_cyc", cyc, re.cyc);
          check("req_we", 32'(bus.MemWe), 32'(re.we));
          check("req_addr", bus.MemAddr, re.addr);
          check("req_be", 32'(bus.MemByteEn), 32'(re.be));
          if (re.we) check("req_wdata", bus.MemWData, re.wd);
        end
        bus.MemAck   = !no_ack && (wcnt == ack_delay);
        bus.MemRData = rd_word;
        wcnt++;
      end else begin
        bus.MemAck = 1'b0;
        wcnt       = 0;
      end
    end
  end

  // Completion monitor.
  initial forever begin
    @(negedge clk);
    if (reset && (LsDone || LsBusErr)) begin
      de = '{berr: 1'bx, rd: 'x, cyc: -1};
      if (dq.size() > 0) de = dq.pop_front();
      check("done_cyc", cyc, de.cyc);
      check("done_berr", 32'(LsBusErr), 32'(de.berr));
      check("done_pulse", 32'(LsDone), 32'(!de.berr));
      check("done_rdata", LsRData, de.rd);
      if (de.berr) check("berr_memreq", 32'(bus.MemReq), 32'd0);
    end
  end

  task automatic op(bit st, logic [1:0] sz, bit sx, logic [31:0] a,
                    logic [31:0] wd, logic [31:0] rw, int dly, bit na);
    req_t  r;
    done_t d;
    int    c0;
    int    n;
    @(posedge clk);
    #1;
    LsValid   = 1'b1;
    LsIsStore = st;
    LsSize    = sz;
    LsSignExt = sx;
    LsAddr    = a;
    LsWData   = wd;
    ack_delay = dly;
    no_ack    = na;
    rd_word   = rw;
    c0        = cyc;
    r.we   = st;
    r.addr = {a[31:2], 2'b00};
    r.be   = exp_be(sz, a);
    r.wd   = exp_wd(sz, wd);
    r.cyc  = c0 + 1;
    rq.push_back(r);
    if (!st && !na) last_rd = fmt(sz, sx, a, rw);
    d.berr = na;
    d.rd   = last_rd;
    d.cyc  = na ? c0 + 1 + TO : c0 + 2 + dly;
    dq.push_back(d);
    n = 0;
    @(negedge clk);
    while (LsStall === 1'b1 && n < TO + 20) begin
      n++;
      @(negedge clk);
    end
    check("stall_cycles", n, na ? 1 + TO : 2 + dly);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    LsValid = 1'b0;
  endtask

  task automatic bad(bit st, logic [1:0] sz, logic [31:0] a);
    @(posedge clk);
    #1;
    LsValid   = 1'b1;
    LsIsStore = st;
    LsSize    = sz;
    LsAddr    = a;
    @(negedge clk);
    check("bad_adel", 32'(LsAdEL), 32'(!st));
    check("bad_ades", 32'(LsAdES), 32'(st));
    check("bad_stall", 32'(LsStall), 32'd0);
    @(posedge clk);
    #1;
    LsValid = 1'b0;
    @(negedge clk);
    check("bad_memreq", 32'(bus.MemReq), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_memreq", 32'(bus.MemReq), 32'd0);
    check("rst_memwe", 32'(bus.MemWe), 32'd0);
    check("rst_memaddr", bus.MemAddr, 32'h0);
    check("rst_be", 32'(bus.MemByteEn), 32'h0);
    check("rst_rdata", LsRData, 32'h0);
    check("rst_done", 32'(LsDone), 32'd0);
    check("rst_stall", 32'(LsStall), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    op(1'b1, 2'b10, 1'b0, 32'h0000_1003, 32'h0000_00AB, 32'h0, 0, 1'b0);
    op(1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 32'h8001_1234, 3, 1'b0);
    op(1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0, 32'h8001_1234, 3, 1'b0);
    op(1'b0, 2'b10, 1'b1, 32'h0000_5001, 32'h0, 32'h1234_F0AA, 0, 1'b0);
    op(1'b0, 2'b10, 1'b0, 32'h0000_5003, 32'h0, 32'h1234_F0AA, 1, 1'b0);
    op(1'b0, 2'b01, 1'b1, 32'h0000_5000, 32'h0, 32'hFFFF_7FFE, 0, 1'b0);
    op(1'b1, 2'b00, 1'b0, 32'h0000_6004, 32'hCAFE_F00D, 32'h0, 2, 1'b0);
    idle();

    bad(1'b0, 2'b00, 32'h0000_3001);
    bad(1'b1, 2'b11, 32'h0000_3000);
    bad(1'b0, 2'b01, 32'h0000_3003);

    op(1'b0, 2'b00, 1'b0, 32'h0000_7000, 32'h0, 32'h1111_2222, 0, 1'b1);
    op(1'b1, 2'b01, 1'b0, 32'h0000_7002, 32'h0000_5A5A, 32'h0, 0, 1'b0);
    idle();

    op(1'b0, 2'b00, 1'b0, 32'h0000_4000, 32'h0, 32'hDEAD_BEEF, 1, 1'b0);
    op(1'b1, 2'b01, 1'b0, 32'h0000_4006, 32'h1234_5678, 32'h0, 1, 1'b0);
    idle();

    // Reset in the middle of a request discards the op.
    @(posedge clk);
    #1;
    LsValid   = 1'b1;
    LsIsStore = 1'b0;
    LsSize    = 2'b00;
    LsAddr    = 32'h0000_8000;
    ack_delay = 1000;
    no_ack    = 1'b0;
    rq.push_back('{we: 1'b0, addr: 32'h0000_8000, be: 4'hF, wd: 32'h0, cyc: cyc + 1});
    repeat (3) @(negedge clk);
    check("mid_memreq_hi", 32'(bus.MemReq), 32'd1);
    #2;
    reset   = 1'b0;
    LsValid = 1'b0;
    #1;
    check("mid_memreq_lo", 32'(bus.MemReq), 32'd0);
    check("mid_stall", 32'(LsStall), 32'd0);
    last_rd = 32'h0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    op(1'b1, 2'b00, 1'b0, 32'h0000_9000, 32'h0BAD_CAFE, 32'h0, 0, 1'b0);
    idle();

    repeat (5) @(negedge clk);
    check("rq_left", rq.size(), 0);
    check("dq_left", dq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
